fft_out_unloader: RTL and testbench

Consumer-side companion to the 8-point pipelined DIT FFT. It captures a full 8-point complex result frame on the FFT's one-cycle `ready` strobe and buffers up to two frames in a ping-pong store. It then streams the samples out one at a time, in natural index order 0..7, over a valid/ack handshake. Samples can optionally be converted from the FFT's sign-magnitude Q7.8 format (sign | 7 integer bits | 8 fraction bits) to two's complement Q7.8.

---
 rtl/fft_out_unloader_pkg.sv | 29 ++
 rtl/fft_sm2tc.sv | 21 ++
 rtl/fft_out_unloader.sv | 132 +++++++++++++
 tb/tb_fft_out_unloader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_unloader_pkg.sv
// Shared constants and helpers for the FFT output unloader: frame geometry,
// the Q7.8 sign-magnitude field layout and the read-side FSM encoding.
package fft_out_unloader_pkg;

  localparam int DW       = 16;
  localparam int NPT      = 8;
  localparam int IDX_W    = $clog2(NPT);

  localparam int SIGN_BIT = 15;
  localparam int INT_MSB  = 14;
  localparam int INT_LSB  = 8;
  localparam int FRAC_MSB = 7;
  localparam int INT_W    = INT_MSB - INT_LSB + 1;
  localparam int FRAC_W   = FRAC_MSB + 1;
  localparam int MAG_W    = INT_W + FRAC_W;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  // Negative zero maps to 0 because -(0) is 0; |magnitude| <= 0x7FFF so no overflow.
  function automatic logic [DW-1:0] sm_to_twos(input logic [DW-1:0] sm);
    logic [DW-1:0] mag;
    mag = {1'b0, sm[MAG_W-1:0]};
    return sm[SIGN_BIT] ? (~mag + 1'b1) : sm;
  endfunction

endpackage

// File: rtl/fft_sm2tc.sv
// Per-sample sign-magnitude to two's complement converter (combinational).
// With EN=0 the sample passes through untouched.
module fft_sm2tc #(
  parameter int DW = 16,
  parameter bit EN = 1'b1
) (
  input  logic [DW-1:0] sm,
  output logic [DW-1:0] tc
);

  if (!EN) begin : g_raw
    assign tc = sm;
  end else if (DW == fft_out_unloader_pkg::DW) begin : g_q78
    assign tc = fft_out_unloader_pkg::sm_to_twos(sm);
  end else begin : g_generic
    logic [DW-1:0] mag;
    assign mag = {1'b0, sm[DW-2:0]};
    assign tc  = sm[DW-1] ? (~mag + 1'b1) : sm;
  end

endmodule

// File: rtl/fft_out_unloader.sv
// Captures 8-point FFT result frames into a two-bank ping-pong store and
// streams them out point by point over a valid/ack handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RD_IDLE   | no frame being presented; dout_valid low
// RD_STREAM | presenting bank rp, point ri; advances on dout_valid & dout_ack
module fft_out_unloader
  import fft_out_unloader_pkg::*;
#(
  parameter bit TO_TWOS = 1'b1
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic               fft_ready,
  input  logic [NPT*DW-1:0]  frame_r,
  input  logic [NPT*DW-1:0]  frame_i,
  output logic [DW-1:0]      dout_r,
  output logic [DW-1:0]      dout_i,
  output logic [IDX_W-1:0]   dout_idx,
  output logic               dout_valid,
  output logic               dout_last,
  input  logic               dout_ack,
  output logic               overflow,
  output logic [7:0]         drop_cnt,
  output logic               busy
);

  rd_state_e          state, state_n;
  logic               wp, rp, rp_n;
  logic [1:0]         cnt, cnt_n;
  logic [IDX_W-1:0]   ri, ri_n;
  logic               xfer, last_xfer, free_bank, capture, drop, load, bypass;
  logic [DW-1:0]      rd_r, rd_i, cv_r, cv_i;

  logic [DW-1:0]      mem_r [2][NPT];
  logic [DW-1:0]      mem_i [2][NPT];

  always_comb begin
    xfer      = dout_valid & dout_ack;
    last_xfer = xfer & (ri == IDX_W'(NPT - 1));
    // A full store still accepts a frame when the oldest bank drains this edge.
    free_bank = (cnt != 2'd2) | last_xfer;
    capture   = fft_ready & free_bank;
    drop      = fft_ready & ~free_bank;
    cnt_n     = cnt + {1'b0, capture} - {1'b0, last_xfer};
    rp_n      = rp ^ last_xfer;
    ri_n      = ri;
    if (last_xfer)
      ri_n = '0;
    else if (xfer)
      ri_n = ri + 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      RD_IDLE:   if (cnt != 2'd0) state_n = RD_STREAM;
      RD_STREAM: if (last_xfer && cnt_n == 2'd0) state_n = RD_IDLE;
      default:   state_n = RD_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    dout_valid = (state == RD_STREAM);
    dout_last  = dout_valid & (ri == IDX_W'(NPT - 1));
    dout_idx   = ri;
    busy       = (cnt != 2'd0);
    load       = ((state == RD_IDLE) && (cnt != 2'd0)) ||
                 (xfer && (state_n == RD_STREAM));
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)
      state <= RD_IDLE;
    else
      state <= state_n;
  end

  // With one frame draining and a new one arriving on its last beat, the
  // next read targets the bank being written this edge, so take the input.
  always_comb begin
    bypass = capture & (wp == rp_n);
    if (bypass) begin
      rd_r = frame_r[32'(ri_n)*DW +: DW];
      rd_i = frame_i[32'(ri_n)*DW +: DW];
    end else begin
      rd_r = mem_r[rp_n][ri_n];
      rd_i = mem_i[rp_n][ri_n];
    end
  end

  fft_sm2tc #(.DW(DW), .EN(TO_TWOS)) u_cv_r (.sm(rd_r), .tc(cv_r));
  fft_sm2tc #(.DW(DW), .EN(TO_TWOS)) u_cv_i (.sm(rd_i), .tc(cv_i));

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NPT; k++) begin
        mem_r[wp][k] <= frame_r[k*DW +: DW];
        mem_i[wp][k] <= frame_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= 2'd0;
      ri       <= '0;
      dout_r   <= '0;
      dout_i   <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      wp       <= wp ^ capture;
      rp       <= rp_n;
      cnt      <= cnt_n;
      ri       <= ri_n;
      overflow <= drop;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (load) begin
        dout_r <= cv_r;
        dout_i <= cv_i;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_unloader.sv
// Directed bench for fft_out_unloader: converting build plus a raw
// (TO_TWOS=0) build sharing the same stimulus.
module tb_fft_out_unloader;

  logic         clk;
  logic         RST_N;
  logic         fft_ready;
  logic [127:0] frame_r, frame_i;
  logic         dout_ack;

  logic [15:0]  dout_r, dout_i;
  logic [2:0]   dout_idx;
  logic         dout_valid, dout_last, overflow, busy;
  logic [7:0]   drop_cnt;

  logic [15:0]  raw_r, raw_i;
  logic [2:0]   raw_idx;
  logic         raw_valid, raw_last, raw_overflow, raw_busy;
  logic [7:0]   raw_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fft_out_unloader #(.TO_TWOS(1'b1)) dut (
    .clk(clk), .RST_N(RST_N), .fft_ready(fft_ready),
    .frame_r(frame_r), .frame_i(frame_i),
    .dout_r(dout_r), .dout_i(dout_i), .dout_idx(dout_idx),
    .dout_valid(dout_valid), .dout_last(dout_last), .dout_ack(dout_ack),
    .overflow(overflow), .drop_cnt(drop_cnt), .busy(busy)
  );

  fft_out_unloader #(.TO_TWOS(1'b0)) dut_raw (
    .clk(clk), .RST_N(RST_N), .fft_ready(fft_ready),
    .frame_r(frame_r), .frame_i(frame_i),
    .dout_r(raw_r), .dout_i(raw_i), .dout_idx(raw_idx),
    .dout_valid(raw_valid), .dout_last(raw_last), .dout_ack(dout_ack),
    .overflow(raw_overflow), .drop_cnt(raw_drop_cnt), .busy(raw_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] t1_in  [8] = '{16'h1C00, 16'h8400, 16'h8200, 16'h8100,
                              16'h8400, 16'h0000, 16'h8000, 16'h0080};
  logic [15:0] t1_exp [8] = '{16'h1C00, 16'hFC00, 16'hFE00, 16'hFF00,
                              16'hFC00, 16'h0000, 16'h0000, 16'h0080};
  logic [15:0] t2_r   [8] = '{16'h0011, 16'h0122, 16'h0233, 16'h0344,
                              16'h0455, 16'h0566, 16'h0677, 16'h0788};
  logic [15:0] t2_i   [8] = '{16'h8001, 16'h8002, 16'h8003, 16'h8004,
                              16'h8005, 16'h8006, 16'h8007, 16'h8008};
  logic [15:0] t2_iex [8] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC,
                              16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8};
  logic [0:23] ack_pat    = 24'b1001_0110_1100_1011_0101_1111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack8(input logic [15:0] w [8]);
    logic [127:0] p;
    for (int k = 0; k < 8; k++) p[k*16 +: 16] = w[k];
    return p;
  endfunction

  function automatic logic [127:0] ramp(input logic [15:0] base);
    logic [127:0] p;
    for (int k = 0; k < 8; k++) p[k*16 +: 16] = base + 16'(k);
    return p;
  endfunction

  task automatic send_frame(input logic [127:0] fr, input logic [127:0] fi);
    fft_ready = 1'b1;
    frame_r   = fr;
    frame_i   = fi;
    tick();
    fft_ready = 1'b0;
  endtask

  // Checks one beat of a ramp frame (real = base+idx, imag = 0).
  task automatic check_ramp_beat(input string nm, input int j, input logic [15:0] base);
    n_tests++;
    if (dout_valid !== 1'b1 || dout_idx !== 3'(j % 8) || dout_r !== base + 16'(j % 8)) begin
      n_fail++;
      $display("FAIL %s beat %0d: got valid=%b idx=%0d r=%h, expected valid=1 idx=%0d r=%h",
               nm, j, dout_valid, dout_idx, dout_r, j % 8, base + 16'(j % 8));
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; fft_ready = 1'b0; dout_ack = 1'b0; frame_r = '0; frame_i = '0;
    #12;
    n_tests++;
    if ({dout_valid, dout_last, dout_idx, overflow, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v=%b l=%b idx=%0d ovf=%b busy=%b, expected all 0",
               dout_valid, dout_last, dout_idx, overflow, busy);
    end
    n_tests++;
    if (dout_r !== 16'h0 || dout_i !== 16'h0 || drop_cnt !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_data: got r=%h i=%h drop=%0d, expected 0 0 0", dout_r, dout_i, drop_cnt);
    end
    @(negedge clk) RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    logic [15:0] zero8 [8] = '{default: 16'h0};
    dout_ack = 1'b1;
    send_frame(pack8(t1_in), pack8(zero8));
    n_tests++;
    if (dout_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_capture: got valid=%b busy=%b, expected valid=0 busy=1", dout_valid, busy);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (dout_valid !== 1'b1 || dout_idx !== 3'(k) || dout_r !== t1_exp[k] ||
          dout_i !== 16'h0 || dout_last !== (k == 7)) begin
        n_fail++;
        $display("FAIL t1_beat %0d: got v=%b idx=%0d r=%h i=%h last=%b, expected v=1 idx=%0d r=%h i=0000 last=%b",
                 k, dout_valid, dout_idx, dout_r, dout_i, dout_last, k, t1_exp[k], k == 7);
      end
      tick();
    end
    n_tests++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout_last !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_end: got valid=%b busy=%b last=%b, expected 0 0 0", dout_valid, busy, dout_last);
    end
    dout_ack = 1'b0;
  endtask

  task automatic test_backpressure();
    int exp_idx = 0;
    int n_xfer  = 0;
    logic        pv = 1'b0, pa = 1'b0;
    logic [2:0]  pidx = '0;
    logic [15:0] pr = '0;
    send_frame(pack8(t2_r), pack8(t2_i));
    for (int c = 0; c < 60 && n_xfer < 8; c++) begin
      if (pv && !pa) begin
        n_tests++;
        if (dout_valid !== 1'b1 || dout_idx !== pidx || dout_r !== pr) begin
          n_fail++;
          $display("FAIL bp_hold cyc %0d: got v=%b idx=%0d r=%h, expected v=1 idx=%0d r=%h",
                   c, dout_valid, dout_idx, dout_r, pidx, pr);
        end
      end
      if (dout_valid) begin
        n_tests++;
        if (dout_idx !== 3'(exp_idx) || dout_r !== t2_r[exp_idx] || dout_i !== t2_iex[exp_idx] ||
            dout_last !== (exp_idx == 7)) begin
          n_fail++;
          $display("FAIL bp_beat %0d: got idx=%0d r=%h i=%h last=%b, expected idx=%0d r=%h i=%h last=%b",
                   exp_idx, dout_idx, dout_r, dout_i, dout_last, exp_idx, t2_r[exp_idx],
                   t2_iex[exp_idx], exp_idx == 7);
        end
      end
      dout_ack = ack_pat[c % 24];
      pv = dout_valid; pa = dout_ack; pidx = dout_idx; pr = dout_r;
      if (dout_valid && dout_ack) begin
        exp_idx++;
        n_xfer++;
      end
      tick();
    end
    dout_ack = 1'b0;
    n_tests++;
    if (n_xfer != 8 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_total: got %0d transfers valid=%b, expected 8 transfers valid=0", n_xfer, dout_valid);
    end
  endtask

  task automatic test_overflow();
    dout_ack = 1'b0;
    send_frame(ramp(16'h0A00), '0);
    send_frame(ramp(16'h0B00), '0);
    n_tests++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pre: got ovf=%b busy=%b, expected 0 1", overflow, busy);
    end
    send_frame(ramp(16'h0C00), '0);
    n_tests++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL ovf_pulse: got ovf=%b drop=%0d, expected 1 1", overflow, drop_cnt);
    end
    tick();
    n_tests++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL ovf_clear: got ovf=%b drop=%0d, expected 0 1", overflow, drop_cnt);
    end
    dout_ack = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check_ramp_beat("ovf_stream", j, (j < 8) ? 16'h0A00 : 16'h0B00);
      tick();
    end
    n_tests++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_end: got valid=%b busy=%b, expected 0 0", dout_valid, busy);
    end
    dout_ack = 1'b0;
  endtask

  task automatic test_simul_release();
    dout_ack = 1'b0;
    send_frame(ramp(16'h0D00), '0);
    send_frame(ramp(16'h0E00), '0);
    tick();
    dout_ack = 1'b1;
    for (int j = 0; j < 24; j++) begin
      check_ramp_beat("simul_stream", j, (j < 8) ? 16'h0D00 : (j < 16) ? 16'h0E00 : 16'h0F00);
      n_tests++;
      if (overflow !== 1'b0 || drop_cnt !== 8'd1) begin
        n_fail++;
        $display("FAIL simul_ovf beat %0d: got ovf=%b drop=%0d, expected 0 1", j, overflow, drop_cnt);
      end
      if (j == 7) begin
        fft_ready = 1'b1;
        frame_r   = ramp(16'h0F00);
        frame_i   = '0;
      end else begin
        fft_ready = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_end: got valid=%b busy=%b, expected 0 0", dout_valid, busy);
    end
    dout_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    dout_ack = 1'b1;
    send_frame(ramp(16'h0500), '0);
    tick();
    for (int j = 0; j < 16; j++) begin
      check_ramp_beat("b2b_stream", j, (j < 8) ? 16'h0500 : 16'h0600);
      if (j == 7) begin
        fft_ready = 1'b1;
        frame_r   = ramp(16'h0600);
        frame_i   = '0;
      end else begin
        fft_ready = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got valid=%b, expected 0", dout_valid);
    end
    dout_ack = 1'b0;
  endtask

  task automatic test_reset_midstream();
    dout_ack = 1'b1;
    send_frame(ramp(16'h0100), '0);
    tick();
    tick(); tick(); tick();
    n_tests++;
    if (dout_valid !== 1'b1 || dout_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_pre: got valid=%b idx=%0d, expected 1 3", dout_valid, dout_idx);
    end
    #2 RST_N = 1'b0;
    #1;
    n_tests++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0 || dout_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_async: got valid=%b busy=%b drop=%0d idx=%0d, expected 0 0 0 0",
               dout_valid, busy, drop_cnt, dout_idx);
    end
    @(negedge clk) RST_N = 1'b1;
    tick();
    n_tests++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: got valid=%b busy=%b, expected 0 0", dout_valid, busy);
    end
    send_frame(ramp(16'h0200), '0);
    tick();
    for (int j = 0; j < 8; j++) begin
      check_ramp_beat("rst_restream", j, 16'h0200);
      tick();
    end
    n_tests++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_end: got valid=%b, expected 0", dout_valid);
    end
    dout_ack = 1'b0;
  endtask

  task automatic test_raw_passthrough();
    logic [15:0] im8 [8] = '{default: 16'h8400};
    dout_ack = 1'b1;
    send_frame(pack8(t1_in), pack8(im8));
    tick();
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (raw_valid !== 1'b1 || raw_idx !== 3'(k) || raw_r !== t1_in[k] || raw_i !== 16'h8400) begin
        n_fail++;
        $display("FAIL raw_beat %0d: got v=%b idx=%0d r=%h i=%h, expected v=1 idx=%0d r=%h i=8400",
                 k, raw_valid, raw_idx, raw_r, raw_i, k, t1_in[k]);
      end
      n_tests++;
      if (dout_r !== t1_exp[k] || dout_i !== 16'hFC00) begin
        n_fail++;
        $display("FAIL conv_beat %0d: got r=%h i=%h, expected r=%h i=fc00", k, dout_r, dout_i, t1_exp[k]);
      end
      tick();
    end
    dout_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_overflow();
    test_simul_release();
    test_back_to_back();
    test_reset_midstream();
    test_raw_passthrough();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
